// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter for the shared enemy sprite ROM.
// Stage A grants one client and registers the ROM address; stage B returns the row byte.

module sprite_rom_arbiter_lane #(
  parameter int ID_W        = 3,
  parameter int NUM_SPRITES = 6
) (
  input  logic            req,
  input  logic            gnt,
  input  logic [ID_W-1:0] sprite,
  input  logic [2:0]      row,
  output logic            eligible,
  output logic [7:0]      addr,
  output logic            err
);
  always_comb begin
    // a client granted this cycle is still presenting the request just accepted
    eligible = req & ~gnt;
    err      = int'(sprite) >= NUM_SPRITES;
    addr     = err ? 8'h00 : 8'({sprite, 3'b000}) + {5'b0, row};
  end
endmodule

module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_SPRITES = 6,
  parameter int ID_W        = 3
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*ID_W-1:0] req_sprite,
  input  logic [NUM_REQ*3-1:0]    req_row,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [7:0]              rsp_data,
  output logic                    rsp_err,
  output logic [7:0]              rom_addr,
  input  logic [7:0]              rom_data,
  output logic                    busy
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic [ID_W-1:0] sprite;
    logic [2:0]      row;
  } fetch_req_t;

  fetch_req_t [NUM_REQ-1:0]      lane_req;
  logic [NUM_REQ-1:0]            eligible;
  logic [NUM_REQ-1:0]            lane_err;
  logic [NUM_REQ-1:0][7:0]       lane_addr;
  logic [1:0][NUM_REQ-1:0]       vld_pipe;  // [0] grant stage, [1] response stage
  logic [NUM_REQ-1:0]            win_oh;
  logic [PTR_W-1:0]              ptr;
  logic [PTR_W-1:0]              win;
  logic [PTR_W-1:0]              ptr_next;
  logic                          win_vld;
  logic                          err_pipe;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    assign lane_req[k] = {req_sprite[k*ID_W +: ID_W], req_row[k*3 +: 3]};

    sprite_rom_arbiter_lane #(
      .ID_W        (ID_W),
      .NUM_SPRITES (NUM_SPRITES)
    ) u_lane (
      .req      (req[k]),
      .gnt      (vld_pipe[0][k]),
      .sprite   (lane_req[k].sprite),
      .row      (lane_req[k].row),
      .eligible (eligible[k]),
      .addr     (lane_addr[k]),
      .err      (lane_err[k])
    );
  end

  // scan from the farthest offset back toward ptr so the nearest eligible client wins
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    win_oh  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[(int'(ptr) + i) % NUM_REQ]) begin
        win     = PTR_W'((int'(ptr) + i) % NUM_REQ);
        win_vld = 1'b1;
      end
    end
    if (win_vld) win_oh[win] = 1'b1;
    ptr_next = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_pipe <= '0;
      ptr      <= '0;
      rom_addr <= '0;
      err_pipe <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      vld_pipe[0] <= win_oh;
      vld_pipe[1] <= vld_pipe[0];
      rsp_err     <= err_pipe & (|vld_pipe[0]);
      if (|vld_pipe[0]) rsp_data <= err_pipe ? 8'h00 : rom_data;
      if (win_vld) begin
        ptr      <= ptr_next;
        rom_addr <= lane_addr[win];
        err_pipe <= lane_err[win];
      end
    end
  end

  assign gnt       = vld_pipe[0];
  assign rsp_valid = vld_pipe[1];
  assign busy      = (|vld_pipe[0]) | (|vld_pipe[1]);
endmodule
